xor_checksum_acc: RTL and testbench

Downstream consumer of the XOR gate output stream. It accepts WIDTH-bit words over a valid/ready handshake and computes a running XOR checksum over each frame. A frame ends after FRAME_LEN words, or earlier on in_last. It then presents the checksum, its parity bit and the word count on a valid/ready output, holding them until the output is consumed.

---
 rtl/xor_pkg.sv | 16 +
 rtl/xor_gate.sv | 12 +
 rtl/xor_checksum_acc.sv | 80 ++++++++
 tb/tb_xor_checksum_acc.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/xor_pkg.sv
// Shared types and helpers for the XOR checksum accumulator slice.
package xor_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Width needed to hold counts 0..frame_len, never narrower than one bit.
    function automatic int count_width(input int frame_len);
        int w;
        w = $clog2(frame_len + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/xor_gate.sv
// Bitwise two-input XOR gate; its z output feeds the checksum datapath.
module xor_gate #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] z
);

    assign z = a ^ b;

endmodule

// File: rtl/xor_checksum_acc.sv
// Running XOR checksum over frames of up to FRAME_LEN words, with a held result
// presented on a valid/ready output until consumed.
module xor_checksum_acc
    import xor_pkg::*;
#(
    parameter  int WIDTH     = 5,
    parameter  int FRAME_LEN = 4,
    localparam int CNT_W     = count_width(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             frame_end;

    xor_gate #(.WIDTH(WIDTH)) u_xor (
        .a (acc),
        .b (in_data),
        .z (acc_next)
    );

    assign cnt_inc   = cnt + CNT_W'(1);
    assign frame_end = in_last || (cnt_inc == CNT_W'(FRAME_LEN));

    // in_ready is decoded from state only, so it never sees out_ready combinationally.
    assign in_ready = (state == ST_ACCUM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ACCUM;
            acc        <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_parity <= 1'b0;
            out_count  <= '0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        if (frame_end) begin
                            out_sum    <= acc_next;
                            out_parity <= ^acc_next;
                            out_count  <= cnt_inc;
                            out_valid  <= 1'b1;
                            acc        <= '0;
                            cnt        <= '0;
                            state      <= ST_HOLD;
                        end else begin
                            acc <= acc_next;
                            cnt <= cnt_inc;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_ACCUM;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_checksum_acc.sv
// Directed self-checking bench for xor_checksum_acc (WIDTH=5, FRAME_LEN=4).
module tb_xor_checksum_acc;

    localparam int WIDTH     = 5;
    localparam int FRAME_LEN = 4;
    localparam int CNT_W     = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_parity;
    logic [CNT_W-1:0] out_count;

    int checks = 0;
    int errors = 0;

    xor_checksum_acc #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_parity (out_parity),
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle so samples sit well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_result(input string tag, input logic [4:0] sum, input logic par, input logic [2:0] count);
        check({tag, " out_valid"},  32'(out_valid),  32'd1);
        check({tag, " in_ready"},   32'(in_ready),   32'd0);
        check({tag, " out_sum"},    32'(out_sum),    32'(sum));
        check({tag, " out_parity"}, 32'(out_parity), 32'(par));
        check({tag, " out_count"},  32'(out_count),  32'(count));
    endtask

    task automatic send(input logic [4:0] data, input logic last);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        tick();
        tick();
        rst = 1'b0;
        check("reset in_ready",   32'(in_ready),   32'd1);
        check("reset out_valid",  32'(out_valid),  32'd0);
        check("reset out_sum",    32'(out_sum),    32'd0);
        check("reset out_parity", 32'(out_parity), 32'd0);
        check("reset out_count",  32'(out_count),  32'd0);

        // Full frame, back to back.
        send(5'h03, 1'b0);
        send(5'h05, 1'b0);
        send(5'h0A, 1'b0);
        send(5'h11, 1'b0);
        check_result("full", 5'h1D, 1'b0, 3'd4);
        tick();
        check("full drain out_valid", 32'(out_valid), 32'd0);
        check("full drain in_ready",  32'(in_ready),  32'd1);
        check("full retain out_sum",  32'(out_sum),   32'h1D);

        // Backpressure: hold result while a pending word waits.
        out_ready = 1'b0;
        send(5'h03, 1'b0);
        send(5'h05, 1'b0);
        send(5'h0A, 1'b0);
        send(5'h11, 1'b0);
        in_valid = 1'b1;
        in_data  = 5'h1F;
        for (int i = 0; i < 3; i++) begin
            check_result("bp hold", 5'h1D, 1'b0, 3'd4);
            tick();
        end
        check_result("bp hold end", 5'h1D, 1'b0, 3'd4);
        out_ready = 1'b1;
        tick();
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready",  32'(in_ready),  32'd1);
        send(5'h1F, 1'b0);
        send(5'h00, 1'b1);
        check_result("bp next frame", 5'h1F, 1'b1, 3'd2);
        tick();

        // Early last.
        send(5'h07, 1'b0);
        send(5'h00, 1'b1);
        check_result("early last", 5'h07, 1'b1, 3'd2);
        tick();

        // Idle gaps between words.
        send(5'h03, 1'b0);
        tick();
        tick();
        send(5'h05, 1'b0);
        tick();
        tick();
        check("gap mid out_valid", 32'(out_valid), 32'd0);
        send(5'h0A, 1'b0);
        tick();
        tick();
        send(5'h11, 1'b0);
        check_result("gaps", 5'h1D, 1'b0, 3'd4);
        tick();

        // in_last on the FRAME_LEN-th word closes the frame once only.
        send(5'h01, 1'b0);
        send(5'h02, 1'b0);
        send(5'h04, 1'b0);
        send(5'h08, 1'b1);
        check_result("last at max", 5'h0F, 1'b0, 3'd4);
        tick();
        check("last at max drain", 32'(out_valid), 32'd0);
        send(5'h10, 1'b1);
        check_result("single word", 5'h10, 1'b1, 3'd1);
        tick();

        // Reset mid-frame discards the partial frame.
        send(5'h1F, 1'b0);
        send(5'h01, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst in_ready",  32'(in_ready),  32'd1);
        check("midrst out_sum",   32'(out_sum),   32'd0);
        check("midrst out_count", 32'(out_count), 32'd0);
        send(5'h00, 1'b0);
        send(5'h00, 1'b0);
        send(5'h00, 1'b0);
        check("midrst no early end", 32'(out_valid), 32'd0);
        send(5'h00, 1'b0);
        check_result("midrst frame", 5'h00, 1'b0, 3'd4);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
